scan_color_sequencer: RTL

// - Scan-out controller for the final-colour datapath: generates VGA timing, pulls one pixel

---
 rtl/video_pkg.sv | 52 +++++
 rtl/pixel_color_mix.sv | 43 ++++
 rtl/scan_color_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the scan-out colour path: default VGA timing,
// pixel record layout and RGB332 field helpers.
package video_pkg;

    // Default 640x480 timing (pixels / lines)
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int PIX_DIV_DEF  = 4;

    // Record and colour field widths
    localparam int COORD_W = 10;
    localparam int COLOR_W = 8;
    localparam int R_W     = 3;
    localparam int G_W     = 3;
    localparam int B_W     = 2;

    typedef logic [COLOR_W-1:0] rgb332_t;
    typedef logic [R_W-1:0]     red_t;
    typedef logic [G_W-1:0]     green_t;
    typedef logic [B_W-1:0]     blue_t;

    localparam rgb332_t UNDERFLOW_COLOR_DEF = 8'hE3;

    // One pixel record as delivered by the shading core
    typedef struct packed {
        logic    shadow;
        logic    link;
        logic    trans;
        rgb332_t link_color;
        rgb332_t tile_color;
    } pix_rec_t;

    // RGB332 layout is {r[7:5], g[4:2], b[1:0]}
    function automatic red_t get_r(input rgb332_t c);
        return c[7:5];
    endfunction

    function automatic green_t get_g(input rgb332_t c);
        return c[4:2];
    endfunction

    function automatic blue_t get_b(input rgb332_t c);
        return c[1:0];
    endfunction

endpackage

// File: rtl/pixel_color_mix.sv
// Combinational colour resolve: pixel record flags and colours plus blank
// produce the RGB332 channels for one pixel.
module pixel_color_mix
    import video_pkg::*;
(
    input  logic     blank,
    input  pix_rec_t rec,
    output red_t     r,
    output green_t   g,
    output blue_t    b
);

    logic covered;

    // A shadow or link object only takes effect when it is not transparent
    assign covered = (rec.shadow || rec.link) && !rec.trans;

    // Priority resolve: blank, then shadow (half-bright tile), link, tile
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        r = '0;
        g = '0;
        b = '0;
        if (blank) begin
            r = '0;
            g = '0;
            b = '0;
        end else if (covered && rec.shadow) begin
            r = get_r(rec.tile_color) >> 1;
            g = get_g(rec.tile_color) >> 1;
            b = get_b(rec.tile_color) >> 1;
        end else if (covered && rec.link) begin
            r = get_r(rec.link_color);
            g = get_g(rec.link_color);
            b = get_b(rec.link_color);
        end else begin
            r = get_r(rec.tile_color);
            g = get_g(rec.tile_color);
            b = get_b(rec.tile_color);
        end
    end

endmodule

// File: rtl/scan_color_sequencer.sv
// Scan-out controller: VGA timing generation, one-record-per-active-pixel
// handshake with the shading core, colour resolve and registered,
// mutually aligned RGB/sync/blank outputs with a sticky underflow flag.
module scan_color_sequencer
    import video_pkg::*;
#(
    parameter int      H_ACTIVE        = H_ACTIVE_DEF,
    parameter int      H_FP            = H_FP_DEF,
    parameter int      H_SYNC          = H_SYNC_DEF,
    parameter int      H_BP            = H_BP_DEF,
    parameter int      V_ACTIVE        = V_ACTIVE_DEF,
    parameter int      V_FP            = V_FP_DEF,
    parameter int      V_SYNC          = V_SYNC_DEF,
    parameter int      V_BP            = V_BP_DEF,
    parameter int      PIX_DIV         = PIX_DIV_DEF,
    parameter rgb332_t UNDERFLOW_COLOR = UNDERFLOW_COLOR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               clr_err,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic               b_shadow,
    input  logic               b_link,
    input  logic               b_trans,
    input  logic [COLOR_W-1:0] link_color,
    input  logic [COLOR_W-1:0] tile_color,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               frame_start,
    output logic [R_W-1:0]     r,
    output logic [G_W-1:0]     g,
    output logic [B_W-1:0]     b,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    // Timing boundaries sized to the counters they are compared against
    localparam logic [COORD_W-1:0] H_ACT_END = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_ACT_END = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0]   div;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;

    logic     tick;
    logic     x_last;
    logic     y_last;
    logic     active;
    logic     hsync_c;
    logic     vsync_c;
    logic     starve;
    pix_rec_t rec;
    red_t     mix_r;
    green_t   mix_g;
    blue_t    mix_b;

    // Pixel tick and position decode, all from the pre-tick counters
    assign tick    = enable && (div == DIV_LAST);
    assign x_last  = (x == H_LAST);
    assign y_last  = (y == V_LAST);
    assign active  = (x < H_ACT_END) && (y < V_ACT_END);
    assign hsync_c = !((x >= HS_START) && (x < HS_END));
    assign vsync_c = !((y >= VS_START) && (y < VS_END));

    // A record is taken only on an active tick with upstream valid
    assign pix_ready   = tick && active && pix_valid;
    assign starve      = tick && active && !pix_valid;
    assign frame_start = tick && (x == '0) && (y == '0);

    assign pix_x = x;
    assign pix_y = y;

    assign rec = '{
        shadow:     b_shadow,
        link:       b_link,
        trans:      b_trans,
        link_color: link_color,
        tile_color: tile_color
    };

    pixel_color_mix u_mix (
        .blank (!active),
        .rec   (rec),
        .r     (mix_r),
        .g     (mix_g),
        .b     (mix_b)
    );

    // Clock divider and raster counters; disabled scan parks at the origin
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            div <= '0;
            x   <= '0;
            y   <= '0;
        end else if (!enable) begin
            div <= '0;
            x   <= '0;
            y   <= '0;
        end else begin
            div <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + COORD_W'(1);
                end else begin
                    x <= x + COORD_W'(1);
                end
            end
        end
    end

    // Output registers: colour, syncs and blank all load on the same tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r     <= '0;
            g     <= '0;
            b     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            blank <= 1'b1;
        end else if (!enable) begin
            r     <= '0;
            g     <= '0;
            b     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            blank <= 1'b1;
        end else if (tick) begin
            hsync <= hsync_c;
            vsync <= vsync_c;
            blank <= !active;
            if (starve) begin
                r <= get_r(UNDERFLOW_COLOR);
                g <= get_g(UNDERFLOW_COLOR);
                b <= get_b(UNDERFLOW_COLOR);
            end else begin
                r <= mix_r;
                g <= mix_g;
                b <= mix_b;
            end
        end
    end

    // Sticky underflow flag; a starve event outranks a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (starve) begin
            underflow <= 1'b1;
        end else if (clr_err) begin
            underflow <= 1'b0;
        end
    end

endmodule
